// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC and fetches one word at a time over a req/ack
// handshake, presenting the latched instruction, its PC and the immediate-format code.
module ifetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [7:0]  control,
   output logic [31:0] pc_out,
   output logic        inst_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic [7:0]  ctrl_q, ctrl_d;
   logic [31:0] pcOut_q, pcOut_d;
   logic        valid_q, valid_d;
   logic        kill_q, kill_d;
   logic [31:0] redirectTarget;

   assign redirectTarget = redirect_pc & ~32'h0000_0003;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= 32'h0;
         instr_q <= 32'h0;
         ctrl_q  <= 8'h0;
         pcOut_q <= 32'h0;
         valid_q <= 1'b0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         ctrl_q  <= ctrl_d;
         pcOut_q <= pcOut_d;
         valid_q <= valid_d;
         kill_q  <= kill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      ctrl_d  = ctrl_q;
      pcOut_d = pcOut_q;
      valid_d = valid_q;
      kill_d  = kill_q;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               pc_d = redirectTarget;
            end else if (!stall) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = REQ;
            end
         end
         REQ: begin
            // A request cannot be withdrawn, so a redirect only marks the in-flight word for discard.
            if (imem_ack) begin
               if (kill_q || redirect_valid) begin
                  req_d   = 1'b0;
                  kill_d  = 1'b0;
                  state_d = IDLE;
                  if (redirect_valid) begin
                     pc_d = redirectTarget;
                  end
               end else begin
                  instr_d = imem_rdata;
                  ctrl_d  = {3'b000, imem_rdata[6:2]};
                  pcOut_d = addr_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + PC_STEP;
                  req_d   = 1'b0;
                  state_d = VALID;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
               pc_d   = redirectTarget;
            end
         end
         VALID: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = redirectTarget;
               state_d = IDLE;
            end else if (!stall) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instruction = instr_q;
   assign control     = ctrl_q;
   assign pc_out      = pcOut_q;
   assign inst_valid  = valid_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: inputs change and outputs are sampled on the falling edge.
module tb_ifetch_stage;

   logic        clk;
   logic        res_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic [31:0] instruction, instruction2;
   logic [7:0]  control, control2;
   logic [31:0] pc_out, pc_out2;
   logic        inst_valid, inst_valid2;

   int compareCount = 0;
   int mismatchCount = 0;

   ifetch_stage dut (
      .clk(clk), .res_n(res_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instruction(instruction), .control(control),
      .pc_out(pc_out), .inst_valid(inst_valid)
   );

   // Second copy starts at the top of the address space to exercise PC wraparound.
   ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .res_n(res_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instruction(instruction2), .control(control2),
      .pc_out(pc_out2), .inst_valid(inst_valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Holds ack low for waitCycles, then returns one word with a one-cycle ack.
   task automatic applyStimulus(input logic [31:0] data, input int waitCycles);
      for (int i = 0; i < waitCycles; i++) tick();
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
   endtask

   task automatic waitForReq(input string tag);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checkOutput(tag, {31'h0, imem_req}, 32'h1);
   endtask

   logic [31:0] heldInstr;

   initial begin
      res_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      tick(); tick();
      checkOutput("rstReq",   {31'h0, imem_req}, 32'h0);
      checkOutput("rstAddr",  imem_addr, 32'h0);
      checkOutput("rstInstr", instruction, 32'h0);
      checkOutput("rstCtrl",  {24'h0, control}, 32'h0);
      checkOutput("rstPcOut", pc_out, 32'h0);
      checkOutput("rstValid", {31'h0, inst_valid}, 32'h0);

      res_n = 1'b1;
      tick();
      checkOutput("firstReq",  {31'h0, imem_req}, 32'h1);
      checkOutput("firstAddr", imem_addr, 32'h0);
      checkOutput("wrapFirstAddr", imem_addr2, 32'hFFFF_FFFC);
      applyStimulus(32'h00A0_0093, 1);
      checkOutput("iValid", {31'h0, inst_valid}, 32'h1);
      checkOutput("iInstr", instruction, 32'h00A0_0093);
      checkOutput("iCtrl",  {24'h0, control}, 32'h04);
      checkOutput("iPcOut", pc_out, 32'h0);
      checkOutput("iReqLow", {31'h0, imem_req}, 32'h0);
      checkOutput("wrapPcOut", pc_out2, 32'hFFFF_FFFC);
      tick();
      checkOutput("secondAddr", imem_addr, 32'h4);
      checkOutput("wrapSecondAddr", imem_addr2, 32'h0);

      applyStimulus(32'hFE11_2E23, 1);
      checkOutput("sCtrl",  {24'h0, control}, 32'h08);
      checkOutput("sPcOut", pc_out, 32'h4);
      tick();
      checkOutput("thirdAddr", imem_addr, 32'h8);
      applyStimulus(32'hFE00_08E3, 1);
      checkOutput("bCtrl",  {24'h0, control}, 32'h18);
      checkOutput("bPcOut", pc_out, 32'h8);

      stall = 1'b1;
      heldInstr = instruction;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stallValid", {31'h0, inst_valid}, 32'h1);
         checkOutput("stallInstr", instruction, 32'hFE00_08E3);
         checkOutput("stallPcOut", pc_out, 32'h8);
         checkOutput("stallReq", {31'h0, imem_req}, 32'h0);
      end
      stall = 1'b0;
      tick();
      checkOutput("postStallReq",  {31'h0, imem_req}, 32'h1);
      checkOutput("postStallAddr", imem_addr, 32'hC);

      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      for (int i = 0; i < 2; i++) begin
         checkOutput("killReq",   {31'h0, imem_req}, 32'h1);
         checkOutput("killAddr",  imem_addr, 32'hC);
         checkOutput("killValid", {31'h0, inst_valid}, 32'h0);
         tick();
      end
      applyStimulus(32'hDEAD_BEEF, 0);
      checkOutput("dropValid", {31'h0, inst_valid}, 32'h0);
      checkOutput("dropReq",   {31'h0, imem_req}, 32'h0);
      tick();
      checkOutput("redirAddr", imem_addr, 32'h0000_0100);
      checkOutput("redirValid", {31'h0, inst_valid}, 32'h0);

      tick();
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      checkOutput("coincValid", {31'h0, inst_valid}, 32'h0);
      checkOutput("coincReq",   {31'h0, imem_req}, 32'h0);
      waitForReq("coincReqTimeout");
      checkOutput("coincAddr", imem_addr, 32'h0000_0200);
      applyStimulus(32'h0000_0013, 1);
      checkOutput("coincPcOut", pc_out, 32'h0000_0200);

      stall = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
      tick();
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      checkOutput("vRedirValid", {31'h0, inst_valid}, 32'h0);
      tick();
      checkOutput("idleStallReq", {31'h0, imem_req}, 32'h0);
      stall = 1'b0;
      tick();
      checkOutput("vRedirAddr", imem_addr, 32'h0000_0040);

      #2 res_n = 1'b0;
      #1;
      checkOutput("asyncReq",   {31'h0, imem_req}, 32'h0);
      checkOutput("asyncValid", {31'h0, inst_valid}, 32'h0);
      checkOutput("asyncAddr",  imem_addr, 32'h0);
      tick();
      res_n = 1'b1;
      tick();
      checkOutput("restartReq",  {31'h0, imem_req}, 32'h1);
      checkOutput("restartAddr", imem_addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
